// File: rtl/drain_sequencer.sv
// Drain sequencer: walks the 7 anti-diagonals of the 4x4 result dispatcher and tags each beat for writeback.
// Optional macro DRAIN_BACKPRESSURE_EN honors wb_ready; without it wb_ready is ignored (always treated as 1).
module drain_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       accumulate,
  input  logic       wb_ready,
  output logic [5:0] count,
  output logic       add_en,
  output logic       busy,
  output logic       wb_valid,
  output logic [3:0] wb_mask,
  output logic [2:0] wb_diag,
  output logic       wb_last,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic        add_en_q, add_en_d;
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_mask_q, wb_mask_d;
  logic [2:0]  wb_diag_q, wb_diag_d;
  logic        wb_last_q, wb_last_d;
  logic        ready;
  logic        adv;

`ifdef DRAIN_BACKPRESSURE_EN
  assign ready = wb_ready;
`else
  logic unused_wb_ready;
  assign unused_wb_ready = wb_ready;
  assign ready = 1'b1;
`endif

  // A stalled beat keeps count frozen so the dispatcher re-registers identical data.
  assign adv = !wb_valid_q || ready;

  function automatic logic [3:0] diag_mask(input logic [2:0] k);
    case (k)
      3'd1, 3'd7: diag_mask = 4'b0001;
      3'd2, 3'd6: diag_mask = 4'b0011;
      3'd3, 3'd5: diag_mask = 4'b0111;
      3'd4:       diag_mask = 4'b1111;
      default:    diag_mask = 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    add_en_d   = add_en_q;
    wb_valid_d = wb_valid_q;
    wb_mask_d  = wb_mask_q;
    wb_diag_d  = wb_diag_q;
    wb_last_d  = wb_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          add_en_d = accumulate;
          count_d  = 6'd1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          wb_valid_d = (count_q != 6'd0);
          wb_diag_d  = count_q[2:0];
          wb_mask_d  = diag_mask(count_q[2:0]);
          wb_last_d  = (count_q == 6'd7);
          if (count_q == 6'd7) begin
            count_d = 6'd0;
            state_d = FLUSH;
          end else begin
            count_d = count_q + 6'd1;
          end
        end
      end
      FLUSH: begin
        if (wb_valid_q && ready && wb_last_q) begin
          wb_valid_d = 1'b0;
          wb_mask_d  = 4'b0000;
          wb_diag_d  = 3'd0;
          wb_last_d  = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        add_en_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 6'd0;
      add_en_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_mask_q  <= 4'b0000;
      wb_diag_q  <= 3'd0;
      wb_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      add_en_q   <= add_en_d;
      wb_valid_q <= wb_valid_d;
      wb_mask_q  <= wb_mask_d;
      wb_diag_q  <= wb_diag_d;
      wb_last_q  <= wb_last_d;
    end
  end

  assign count    = count_q;
  assign add_en   = add_en_q;
  assign busy     = (state_q == RUN) || (state_q == FLUSH);
  assign done     = (state_q == DONE);
  assign wb_valid = wb_valid_q;
  assign wb_mask  = wb_mask_q;
  assign wb_diag  = wb_diag_q;
  assign wb_last  = wb_last_q;

endmodule

// File: tb/tb_drain_sequencer.sv
// Directed self-checking bench for drain_sequencer; stall expectations follow DRAIN_BACKPRESSURE_EN.
module tb_drain_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       accumulate;
  logic       wb_ready;
  logic [5:0] count;
  logic       add_en;
  logic       busy;
  logic       wb_valid;
  logic [3:0] wb_mask;
  logic [2:0] wb_diag;
  logic       wb_last;
  logic       done;

  int checks = 0;
  int errors = 0;
  int doneCount;

  always #5 clk = ~clk;

  drain_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .accumulate (accumulate),
    .wb_ready   (wb_ready),
    .count      (count),
    .add_en     (add_en),
    .busy       (busy),
    .wb_valid   (wb_valid),
    .wb_mask    (wb_mask),
    .wb_diag    (wb_diag),
    .wb_last    (wb_last),
    .done       (done)
  );

  // Cycle k is the window after clock edge k-1; inputs and checks both sit 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start      = s;
    accumulate = a;
    wb_ready   = r;
  endtask

  task automatic checkOutput(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] maskOf(input int k);
    case (k)
      1, 7:    maskOf = 4'h1;
      2, 6:    maskOf = 4'h3;
      3, 5:    maskOf = 4'h7;
      4:       maskOf = 4'hF;
      default: maskOf = 4'h0;
    endcase
  endfunction

  task automatic checkBeat(input int cyc, input int expCount, input int expDiag, input bit expDone, input bit expBusy);
    bit v;
    v = (expDiag != 0);
    checkOutput("count", cyc, 32'(count), 32'(expCount));
    checkOutput("wb_valid", cyc, 32'(wb_valid), 32'(v));
    checkOutput("wb_diag", cyc, 32'(wb_diag), 32'(expDiag));
    checkOutput("wb_mask", cyc, 32'(wb_mask), 32'(maskOf(expDiag)));
    checkOutput("wb_last", cyc, 32'(wb_last), 32'(expDiag == 7));
    checkOutput("done", cyc, 32'(done), 32'(expDone));
    checkOutput("busy", cyc, 32'(busy), 32'(expBusy));
  endtask

  // Unstalled job from IDLE: count 1..7 in cycles 1..7, beats in 2..8, done in 9, idle from 10.
  task automatic runPlainJob(input logic acc, input logic rdy);
    applyStimulus(1'b1, acc, rdy);
    tick();
    applyStimulus(1'b0, acc, rdy);
    for (int c = 1; c <= 11; c++) begin
      checkBeat(c, (c <= 7) ? c : 0, (c >= 2 && c <= 8) ? c - 1 : 0, c == 9, c <= 8);
      if (c != 9)
        checkOutput("add_en", c, 32'(add_en), 32'((c <= 8) ? acc : 1'b0));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkBeat(0, 0, 0, 1'b0, 1'b0);
    checkOutput("reset add_en", 0, 32'(add_en), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] pass-through job");
    runPlainJob(1'b0, 1'b1);

    $display("[TB] accumulate job with ignored start pulses");
    doneCount = 0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    for (int c = 1; c <= 12; c++) begin
      applyStimulus((c == 3) || (c == 9), 1'b1, 1'b1);
      checkBeat(c, (c <= 7) ? c : 0, (c >= 2 && c <= 8) ? c - 1 : 0, c == 9, c <= 8);
      if (c != 9)
        checkOutput("add_en", c, 32'(add_en), 32'(c <= 8));
      if (done) doneCount++;
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("done pulses", 13, 32'(doneCount), 32'd1);

    $display("[TB] stall while beat 4 is presented");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    for (int c = 1; c <= 13; c++) begin
      int ec;
      int ed;
      applyStimulus(1'b0, 1'b0, !(c >= 5 && c <= 7));
`ifdef DRAIN_BACKPRESSURE_EN
      ec = (c <= 5) ? c : (c <= 8) ? 5 : (c == 9) ? 6 : (c == 10) ? 7 : 0;
      ed = (c < 2) ? 0 : (c <= 5) ? c - 1 : (c <= 8) ? 4 : (c <= 11) ? c - 4 : 0;
      checkBeat(c, ec, ed, c == 12, c <= 11);
`else
      ec = (c <= 7) ? c : 0;
      ed = (c >= 2 && c <= 8) ? c - 1 : 0;
      checkBeat(c, ec, ed, c == 9, c <= 8);
`endif
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    checkOutput("count before abort", 4, 32'(count), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    checkBeat(4, 0, 0, 1'b0, 1'b0);
    checkOutput("add_en abort", 4, 32'(add_en), 32'd0);
    doneCount = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) doneCount++;
    end
    rst = 1'b0;
    tick();
    checkOutput("done after abort", 0, 32'(doneCount + int'(done)), 32'd0);
    runPlainJob(1'b1, 1'b1);

`ifndef DRAIN_BACKPRESSURE_EN
    $display("[TB] wb_ready held low without backpressure");
    runPlainJob(1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drain_sequencer.md
# drain_sequencer

Controller that drives the `count` and `shouldAdd` inputs of the 4x4 anti-diagonal result dispatcher. It walks the seven anti-diagonals of the result array and tags each registered output beat with valid lanes and a diagonal index. It applies downstream backpressure by freezing the diagonal index. It sits between the array control FSM, which issues `start`, and the writeback/result-buffer logic, which consumes `d1..d4` together with this block's `wb_*` outputs.

## Interface
- No parameters. Array size is fixed at 4x4, giving 7 diagonals.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a drain job; sampled only in IDLE.
- `accumulate` in 1: job mode, sampled with `start`. 1 = add partials (`shouldAdd`), 0 = pass-through.
- `wb_ready` in 1: downstream accepts the current beat.
- `count` out 6: diagonal select to dispatcher; 0 = idle, 1..7 = diagonal.
- `add_en` out 1: to dispatcher `shouldAdd`; held constant for the whole job.
- `busy` out 1: job in progress (RUN or FLUSH).
- `wb_valid` out 1: dispatcher outputs `d1..d4` hold a valid diagonal.
- `wb_mask` out 4: lanes valid in the current beat; bit0 = `d1`.
- `wb_diag` out 3: diagonal index (1..7) of the current beat.
- `wb_last` out 1: current beat is diagonal 7.
- `done` out 1: one-cycle pulse when the job completes.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - `count`=0.
  - On `start`=1, latch `add_en`=`accumulate`, set `count`=1, go to RUN.
- RUN:
  - Define `adv` = !`wb_valid` || `wb_ready`.
  - On `adv` with `count`<7: `count` increments.
  - On `adv` with `count`=7: `count`=0, go to FLUSH.
  - On !`adv`: `count` holds. The dispatcher then re-registers identical data, so `d1..d4` are stable.
- Writeback stage, a 1-cycle shadow of the dispatcher register:
  - On `adv`, `wb_valid`<=(`count`!=0), `wb_diag`<=`count`[2:0], `wb_mask`<=mask(`count`), `wb_last`<=(`count`==7).
- mask(k) sets the low min(k, 8-k) bits:
  - k = 1 and 7: 0001.
  - k = 2 and 6: 0011.
  - k = 3 and 5: 0111.
  - k = 4: 1111.
- FLUSH: when `wb_valid` && `wb_ready` && `wb_last`, clear `wb_valid` and go to DONE.
- DONE: `done`=1 for exactly one cycle, `add_en`<=0, then IDLE.
- `start` outside IDLE (RUN, FLUSH, DONE) is ignored. It is not queued.
- `wb_mask`, `wb_diag` and `wb_last` are 0 whenever `wb_valid`=0.
- Reset while any job is in progress aborts immediately. There is no drain and no `done` pulse.

## Timing
- Reset values (asynchronous, on `rst`=1):
  - state=IDLE.
  - `count`, `add_en`, `busy`, `wb_valid`, `wb_mask`, `wb_diag`, `wb_last`, `done` all 0.
- `busy`=1 from the cycle after `start` is accepted until DONE; it is 0 in DONE.
- Latency: diagonal k is on `count` in cycle t, and the corresponding `d*` and `wb_valid` appear in cycle t+1.
- No-stall job: `start` sampled at edge 0.
  - `count`=1..7 in cycles 1..7.
  - `wb_valid` in cycles 2..8.
  - `done` in cycle 9.
  - IDLE in cycle 10, the earliest cycle a new `start` is accepted.
- Stall: each cycle with `wb_valid`=1 and `wb_ready`=0 delays all later events by one cycle. A beat is never dropped or duplicated.
- All outputs are registered; no combinational path from `wb_ready` to any output.

## Configuration
- `DRAIN_BACKPRESSURE_EN` defined:
  - `wb_ready` is honored as described above.
- `DRAIN_BACKPRESSURE_EN` undefined:
  - `wb_ready` is ignored and treated as 1, and `adv` is always 1.
  - The job always takes exactly 9 cycles from `start` to `done`.

## Test plan
- Reset, then `start`=1, `accumulate`=0, `wb_ready`=1 -> `count` steps 1..7 in cycles 1..7, `add_en`=0, `done` in cycle 9.
- Same as above with `accumulate`=1 -> `add_en`=1 in cycles 1..8 and 0 after DONE; `wb_mask` sequence is 1,3,7,F,7,3,1 with `wb_diag` 1..7, and `wb_last` only on beat 7.
- `wb_ready`=0 for 3 cycles while `wb_diag`=4 -> `count` holds at 5, `wb_mask`=F holds, and `done` moves to cycle 12.
- `start` pulsed again in cycles 3 and 9 -> ignored; only one `done` pulse.
- `rst`=1 asserted mid-RUN at `count`=4 -> all outputs 0 immediately with no `done`; a new `start` runs a full job normally.
- With `DRAIN_BACKPRESSURE_EN` undefined and `wb_ready` held at 0 -> job completes in 9 cycles, identical to the no-stall case.
